// File: rtl/sfx_duck_scheduler.sv
// Schedules sound-effect requesters onto the single SFX channel, ducks the music with a
// stepped gain ramp while an effect plays, and produces the saturated mixed sample.
module sfx_duck_scheduler #(
  parameter int NUM_SFX       = 4,
  parameter int SFX_SAMPLES   = 4800,
  parameter int DUCK_MIN_GAIN = 4,
  parameter int RAMP_STEP     = 64,
  localparam int SelW         = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic               en_music,
  input  logic [NUM_SFX-1:0] req,
  input  logic signed [15:0] music_in,
  input  logic signed [15:0] sfx_in,
  output logic               sfx_start,
  output logic [SelW-1:0]    sfx_sel,
  output logic               sfx_active,
  output logic [4:0]         music_gain,
  output logic signed [15:0] mix_out
);

  localparam int CntW  = $clog2(SFX_SAMPLES + 1);
  localparam int RampW = $clog2(RAMP_STEP + 1);
  localparam logic [4:0] FullGain = 5'd16;
  localparam logic [4:0] DuckGain = (DUCK_MIN_GAIN > 16) ? 5'd16 :
                                    (DUCK_MIN_GAIN < 0)  ? 5'd0  : 5'(DUCK_MIN_GAIN);
  localparam logic [CntW-1:0]  LastCnt  = CntW'(SFX_SAMPLES - 1);
  localparam logic [RampW-1:0] LastRamp = RampW'(RAMP_STEP - 1);

  typedef enum logic [1:0] {IDLE, GRANT, PLAY} state_e;

  function automatic logic [SelW-1:0] topBit(input logic [NUM_SFX-1:0] v);
    topBit = '0;
    for (int i = 0; i < NUM_SFX; i++)
      if (v[i]) topBit = SelW'(i);
  endfunction

  function automatic logic [NUM_SFX-1:0] oneHot(input logic [SelW-1:0] idx);
    oneHot = {{(NUM_SFX-1){1'b0}}, 1'b1} << idx;
  endfunction

  state_e             state_q, state_d;
  logic [NUM_SFX-1:0] pending_q, pending_d;
  logic [SelW-1:0]    sel_q, sel_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               start_q, start_d;
  logic [4:0]         gain_q, gain_d, target_q, target;
  logic [RampW-1:0]   ramp_q, ramp_d;
  logic signed [15:0] mix_q, mix_d;
  logic [SelW-1:0]    reqTop, pendTop;
  logic signed [21:0] prod, shifted;
  logic signed [17:0] mTerm, sTerm, sum;

  assign reqTop  = topBit(req);
  assign pendTop = topBit(pending_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      gain_q    <= FullGain;
      target_q  <= FullGain;
      ramp_q    <= '0;
      mix_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      gain_q    <= gain_d;
      target_q  <= target;
      ramp_q    <= ramp_d;
      mix_q     <= mix_d;
    end
  end

  // A final tick wins over any request in the same cycle: requests then only queue.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        pending_d = pending_q | req;
        if (pending_q != '0) state_d = GRANT;
      end
      GRANT: begin
        pending_d = (pending_q & ~oneHot(pendTop)) | req;
        sel_d     = pendTop;
        start_d   = 1'b1;
        cnt_d     = '0;
        state_d   = PLAY;
      end
      PLAY: begin
        if (sample_tick && cnt_q == LastCnt) begin
          pending_d = pending_q | req;
          state_d   = ((pending_q | req) != '0) ? GRANT : IDLE;
        end else begin
          if (sample_tick) cnt_d = cnt_q + CntW'(1);
          if (req != '0 && reqTop > sel_q) begin
            pending_d = (pending_q | req) & ~oneHot(reqTop) & ~oneHot(sel_q);
            sel_d     = reqTop;
            start_d   = 1'b1;
            cnt_d     = '0;
          end else if (req != '0 && reqTop == sel_q) begin
            pending_d = pending_q | (req & ~oneHot(sel_q));
            start_d   = 1'b1;
            cnt_d     = '0;
          end else begin
            pending_d = pending_q | req;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gain steps one unit per RAMP_STEP ticks; a target change restarts the step interval.
  always_comb begin
    target = (state_q == PLAY) ? DuckGain : FullGain;
    gain_d = gain_q;
    ramp_d = ramp_q;
    if (target != target_q) begin
      ramp_d = '0;
    end else if (sample_tick) begin
      if (ramp_q == LastRamp) begin
        ramp_d = '0;
        if (gain_q > target)      gain_d = gain_q - 5'd1;
        else if (gain_q < target) gain_d = gain_q + 5'd1;
      end else begin
        ramp_d = ramp_q + RampW'(1);
      end
    end
  end

  assign prod    = $signed({{6{music_in[15]}}, music_in}) * $signed({17'd0, gain_q});
  assign shifted = prod >>> 4;
  assign mTerm   = en_music ? shifted[17:0] : '0;
  assign sTerm   = (state_q == PLAY) ? {{2{sfx_in[15]}}, sfx_in} : '0;
  assign sum     = mTerm + sTerm;

  always_comb begin
    if (sum > 18'sd32767)       mix_d = 16'sh7fff;
    else if (sum < -18'sd32768) mix_d = 16'sh8000;
    else                        mix_d = sum[15:0];
  end

  assign sfx_start  = start_q;
  assign sfx_sel    = sel_q;
  assign sfx_active = (state_q == PLAY);
  assign music_gain = gain_q;
  assign mix_out    = mix_q;

endmodule
